// File: rtl/uart9_rx.sv
// Serial receiver for the 9-bit UART link: start + 9 data bits (LSB first) + stop,
// delivered through a one-entry valid/ready holding register.
module uart9_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [8:0] rx_word,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_e;

  state_e             state_q, state_d;
  logic               rxd_meta_q, rxd_s_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic [8:0]         shift_q, shift_d;
  logic               pend_q, pend_d;
  logic [8:0]         rx_word_q, rx_word_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               half_done, bit_done;

  // Two-flop synchronizer; idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pend_q      <= 1'b0;
      rx_word_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      rx_word_q   <= rx_word_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign half_done = (cnt_q == CNT_W'(HALF_BIT - 1));
  assign bit_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    pend_d      = 1'b0;
    rx_word_d   = rx_word_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (half_done) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[8:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd8) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            pend_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BRK;
          end
        end
      end
      S_BRK: begin
        // Hold off until the line returns high so a break cannot retrigger
        cnt_d = '0;
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // Load a completed frame one cycle after its stop sample
    if (pend_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_word_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_word   = rx_word_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart9_rx.sv
// Directed bench for uart9_rx at CLKS_PER_BIT=4 with a word scoreboard and pulse counters.
module tb_uart9_rx;

  localparam int unsigned CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [8:0] rx_word;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int n_chk  = 0;
  int n_pass = 0;
  int vcyc   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [8:0] exp_q[$];

  uart9_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_word  (rx_word),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the first nbits line bits of a frame: start, d0..d8, stop
  task automatic send_bits(input logic [8:0] word, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, word, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rxd = f[i];
      repeat (CPB) tick();
    end
  endtask

  // Monitor: count pulses and score each transfer against the expected queue
  always @(negedge clk) begin
    if (rx_valid) vcyc++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid && rx_ready) begin
      chk("sb_expected_word", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_word", 32'(rx_word), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int v0, f0, o0;
    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_word", 32'(rx_word), 32'h0);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Single good frame with consumer ready
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(9'h106);
    send_bits(9'h106, 1'b1, 11);
    repeat (20) tick();
    chk("t1_valid_cycles", 32'(vcyc - v0), 32'd1);
    chk("t1_frame_err", 32'(fe_cnt - f0), 32'd0);
    chk("t1_overrun", 32'(ov_cnt - o0), 32'd0);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_word", 32'(rx_word), 32'h106);

    // Two frames with consumer stalled: second is dropped
    f0 = fe_cnt; o0 = ov_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(9'h0F0);
    send_bits(9'h0F0, 1'b1, 11);
    send_bits(9'h105, 1'b1, 11);
    repeat (10) tick();
    chk("t2_word", 32'(rx_word), 32'h0F0);
    chk("t2_valid", 32'(rx_valid), 32'd1);
    chk("t2_overrun", 32'(ov_cnt - o0), 32'd1);
    chk("t2_frame_err", 32'(fe_cnt - f0), 32'd0);

    // Transfer in the exact load cycle: no overrun, new word replaces old
    o0 = ov_cnt;
    exp_q.push_back(9'h105);
    send_bits(9'h105, 1'b1, 11);
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (3) tick();
    chk("t3_valid", 32'(rx_valid), 32'd1);
    chk("t3_word", 32'(rx_word), 32'h105);
    chk("t3_overrun", 32'(ov_cnt - o0), 32'd0);
    chk("t3_pending", 32'(exp_q.size()), 32'd1);
    rx_ready = 1'b1;
    repeat (2) tick();
    chk("t3_drain_valid", 32'(rx_valid), 32'd0);
    chk("t3_drain_q", 32'(exp_q.size()), 32'd0);

    // Bad stop bit followed by a held-low line
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    send_bits(9'h055, 1'b0, 11);
    repeat (20) tick();
    chk("t4_frame_err", 32'(fe_cnt - f0), 32'd1);
    chk("t4_valid_low", 32'(rx_valid), 32'd0);
    rxd = 1'b1;
    repeat (60) tick();
    chk("t4_frame_err_once", 32'(fe_cnt - f0), 32'd1);
    chk("t4_no_word", 32'(vcyc - v0), 32'd0);
    chk("t4_overrun", 32'(ov_cnt - o0), 32'd0);

    // One-cycle glitch on the idle line
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (60) tick();
    chk("t5_no_word", 32'(vcyc - v0), 32'd0);
    chk("t5_frame_err", 32'(fe_cnt - f0), 32'd0);
    chk("t5_overrun", 32'(ov_cnt - o0), 32'd0);

    // Reset during d4, then a clean frame
    send_bits(9'h00E, 1'b1, 5);
    rxd = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_word", 32'(rx_word), 32'h0);
    chk("t6_rst_valid", 32'(rx_valid), 32'd0);
    chk("t6_rst_frame_err", 32'(frame_err), 32'd0);
    chk("t6_rst_overrun", 32'(overrun), 32'd0);
    rxd = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(9'h00E);
    send_bits(9'h00E, 1'b1, 11);
    repeat (20) tick();
    chk("t6_valid_cycles", 32'(vcyc - v0), 32'd1);
    chk("t6_word", 32'(rx_word), 32'h00E);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_no_pulses", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
